fixed_point_div_scheduler: RTL and testbench
============================================

# fixed_point_div_scheduler

- Shares one sequential signed fixed-point long-division core between N_REQ requesters.
- Arbitration is round-robin. Each request is a valid/ready operand handshake. Each reply uses a per-requester response handshake.
- The block sequences the core with start/busy/done, saturates divide-by-zero without using the core, and flags a core that never completes.
- It sits between the DSP filter channels and the single `simpleFixedPointSignedLongDivision`-class core.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, two's-complement operand/quotient width
- TIMEOUT, 64, maximum WAIT cycles before error response
- i_clk  in  1  single clock, rising edge
- i_reset_n  in  1  reset, synchronous, active-low
- i_req_valid  in  N_REQ  per-requester request valid
- i_req_dividend  in  N_REQ*DATA_W  packed dividends, requester k at [k*DATA_W +: DATA_W]
- i_req_divisor  in  N_REQ*DATA_W  packed divisors, same packing
- o_req_ready  out  N_REQ  one-hot accept strobe
- o_rsp_valid  out  N_REQ  one-hot response valid
- i_rsp_ready  in  N_REQ  per-requester response ready
- o_rsp_quotient  out  DATA_W  shared response quotient
- o_rsp_dbz  out  1  divide-by-zero flag, qualified by o_rsp_valid
- o_rsp_err  out  1  core timeout flag, qualified by o_rsp_valid
- o_div_start  out  1  one-cycle start pulse to core
- o_div_dividend, o_div_divisor  out  DATA_W each  latched operands, stable from start to done
- i_div_busy  in  1  core busy
- i_div_done  in  1  core one-cycle completion pulse
- i_div_quotient  in  DATA_W  core result, valid with i_div_done

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE:** if any i_req_valid, the arbiter selects grant g, searching from (last+1) mod N_REQ upward with wrap.
  - o_req_ready[g] = 1 combinationally in this cycle; this is the transfer.
  - Operands and g are latched; last <= g.
  - Divisor == 0: skip the core and go to RESP. Quotient = 0x7F..F if dividend[MSB] == 0, else 0x80..0; dbz = 1.
  - Otherwise go to ISSUE.
- **ISSUE:** o_div_start = 1 while !i_div_busy, then go to WAIT. If busy, hold with start = 0. i_div_done is ignored in ISSUE.
- **WAIT:** count cycles from 0.
  - i_div_done: capture i_div_quotient and go to RESP with dbz = 0, err = 0.
  - Count reaches TIMEOUT-1 without done: go to RESP with quotient 0, err = 1.
- **RESP:** o_rsp_valid[g] = 1 and quotient/flags held stable until i_rsp_ready[g] = 1. Then go to IDLE.
- i_div_done outside WAIT is ignored, including a late done after a timeout.
- Only one transaction is in flight. All o_req_ready = 0 outside IDLE.
- The quotient is passed through unmodified; fixed-point format is owned by the core.

## Timing
- Reset, sampled at a rising edge with i_reset_n = 0:
  - state IDLE, last = N_REQ-1 (requester 0 highest priority).
  - Registered outputs 0: o_rsp_valid, o_rsp_quotient, o_rsp_dbz, o_rsp_err, o_div_start, o_div_dividend, o_div_divisor.
  - o_req_ready = 0 while i_reset_n = 0.
- Reset mid-operation abandons the transaction with no response.
- Accept at cycle T → o_div_start at T+1 if core idle.
- i_div_done at cycle D → o_rsp_valid from D+1.
- Divide-by-zero: accept at T → o_rsp_valid at T+1.
- Response accepted at cycle R → IDLE at R+1 → next o_req_ready earliest R+1. Throughput is at most one request per core latency + 3 cycles.
- A requester that drops i_req_valid before grant is simply not selected.
- Simultaneous requests are resolved purely by the round-robin pointer.

## Structure
- Package div_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), function sat_value(DATA_W, sign), timeout counter width $clog2(TIMEOUT).
- Sub-module rr_arbiter (N_REQ, req, last, one-hot grant, grant index) is combinational; the pointer register stays in the top.

## Test plan
Benches use a core model with a fixed 8-cycle latency unless noted; N_REQ = 4, DATA_W = 8.

- **Single request:** req0 dividend 0x30, divisor 0x20 (Q4.4 3.0/2.0), model returns 0x18 → o_div_start 1 cycle after accept, o_rsp_valid[0] with quotient 0x18, dbz = 0, err = 0.
- **Round-robin:** all four valid from reset and re-asserted after each response → grant order 0,1,2,3,0. Then with only req1 and req3 valid after a req0 grant → order 1,3.
- **Divide-by-zero:** dividend 0x30 / 0x00 → quotient 0x7F, dbz = 1 at T+1, o_div_start never asserted. Dividend 0xD0 / 0x00 → quotient 0x80.
- **Backpressure:** i_rsp_ready[2] low for 5 cycles → o_rsp_valid[2] and quotient held constant, no o_req_ready while req0 is valid, then accept the cycle after release.
- **Busy and timeout:** i_div_busy high for 3 cycles at ISSUE delays start by 3. A model that never sends done → err = 1 and quotient 0 after 64 WAIT cycles. A late done afterwards does not change the following transaction.
- **Reset mid-WAIT:** i_reset_n low for one edge → all outputs 0 next cycle, no response issued; with all requests valid, the next grant goes to req0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared state encoding and helpers for the divide scheduler
package div_sched_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam int MAX_W = 32;

  // Most-positive value for a non-negative dividend, most-negative otherwise.
  function automatic logic [MAX_W-1:0] sat_value(input int data_w, input logic sign);
    logic [MAX_W-1:0] v;
    v = MAX_W'(1) << (data_w - 1);
    if (!sign) v = v - MAX_W'(1);
    return v;
  endfunction

  function automatic int cnt_w(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/fixed_point_div_scheduler_if.sv
// rtl/fixed_point_div_scheduler_if.sv - requester and core handshake bundle
interface fixed_point_div_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ*DATA_W-1:0] i_req_dividend;
  logic [N_REQ*DATA_W-1:0] i_req_divisor;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [N_REQ-1:0]        i_rsp_ready;
  logic [DATA_W-1:0]       o_rsp_quotient;
  logic                    o_rsp_dbz;
  logic                    o_rsp_err;
  logic                    o_div_start;
  logic [DATA_W-1:0]       o_div_dividend;
  logic [DATA_W-1:0]       o_div_divisor;
  logic                    i_div_busy;
  logic                    i_div_done;
  logic [DATA_W-1:0]       i_div_quotient;

  modport slave (
    input  i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
    input  i_div_busy, i_div_done, i_div_quotient,
    output o_req_ready, o_rsp_valid, o_rsp_quotient, o_rsp_dbz, o_rsp_err,
    output o_div_start, o_div_dividend, o_div_divisor
  );

  modport master (
    output i_req_valid, i_req_dividend, i_req_divisor, i_rsp_ready,
    output i_div_busy, i_div_done, i_div_quotient,
    input  o_req_ready, o_rsp_valid, o_rsp_quotient, o_rsp_dbz, o_rsp_err,
    input  o_div_start, o_div_dividend, o_div_divisor
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx         = '0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = IDX_W'((int'(i_last) + i) % N_REQ);
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant_idx  = idx;
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_point_div_scheduler.sv
// rtl/fixed_point_div_scheduler.sv - shares one sequential divider among N_REQ requesters
module fixed_point_div_scheduler
  import div_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic                         i_clk,
  input logic                         i_reset_n,
  fixed_point_div_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_gidx;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_q;
  logic              r_dbz;
  logic              r_err;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_any;
  logic              w_accept;
  logic              w_timeout;
  logic [DATA_W-1:0] w_sel_dvd;
  logic [DATA_W-1:0] w_sel_dvs;
  logic              w_sel_zero;
  logic [DATA_W-1:0] w_sat;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req       (bus.i_req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  assign w_sel_dvd  = bus.i_req_dividend[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_sel_dvs  = bus.i_req_divisor[int'(w_gidx)*DATA_W +: DATA_W];
  assign w_sel_zero = (w_sel_dvs == '0);
  assign w_sat      = DATA_W'(sat_value(DATA_W, w_sel_dvd[DATA_W-1]));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_timeout       = 1'b0;
    bus.o_req_ready = '0;
    bus.o_rsp_valid = '0;
    bus.o_div_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && i_reset_n) begin
          bus.o_req_ready = w_grant;
          w_accept        = 1'b1;
          w_state_nxt     = w_sel_zero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.i_div_busy) begin
          bus.o_div_start = 1'b1;
          w_state_nxt     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_div_done) begin
          w_state_nxt = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.o_rsp_valid[r_gidx] = 1'b1;
        if (bus.i_rsp_ready[r_gidx]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only move on accept (divide-by-zero) or when leaving WAIT.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_last <= IDX_W'(N_REQ - 1);
      r_gidx <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_dbz  <= 1'b0;
      r_err  <= 1'b0;
      r_dvd  <= '0;
      r_dvs  <= '0;
    end else begin
      if (w_accept) begin
        r_last <= w_gidx;
        r_gidx <= w_gidx;
        r_dvd  <= w_sel_dvd;
        r_dvs  <= w_sel_dvs;
        if (w_sel_zero) begin
          r_q   <= w_sat;
          r_dbz <= 1'b1;
          r_err <= 1'b0;
        end
      end
      if (r_state == ST_ISSUE)     r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_WAIT) begin
        if (bus.i_div_done) begin
          r_q   <= bus.i_div_quotient;
          r_dbz <= 1'b0;
          r_err <= 1'b0;
        end else if (w_timeout) begin
          r_q   <= '0;
          r_dbz <= 1'b0;
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.o_rsp_quotient = r_q;
  assign bus.o_rsp_dbz      = r_dbz;
  assign bus.o_rsp_err      = r_err;
  assign bus.o_div_dividend = r_dvd;
  assign bus.o_div_divisor  = r_dvs;

endmodule

// File: tb/tb_fixed_point_div_scheduler.sv
// tb/tb_fixed_point_div_scheduler.sv - randomized self-checking bench for the divide scheduler
module tb_fixed_point_div_scheduler;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_div_scheduler_if #(.N_REQ(N), .DATA_W(W)) bus ();

  fixed_point_div_scheduler #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  logic [7:0] dvd [N];
  logic [7:0] dvs [N];
  int   model_last;
  int   prev_rsp;
  int   last_g;
  logic [7:0] last_q;
  logic inj_busy;
  logic stray_done;
  int   core_lat;
  logic core_hang;

  logic       core_busy = 1'b0;
  logic       core_done = 1'b0;
  logic [7:0] core_q = 8'h00;
  logic       core_active = 1'b0;
  int         core_cnt = 0;
  int         n_starts = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  logic       st;

  assign bus.i_div_busy     = core_busy | inj_busy;
  assign bus.i_div_done     = core_done | stray_done;
  assign bus.i_div_quotient = stray_done ? 8'h55 : core_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Q4.4 signed divide, saturated to 8 bits: the behaviour of the external core.
  function automatic logic [7:0] core_fn(input logic [7:0] a, input logic [7:0] b);
    int q;
    if (b == 8'h00) return 8'h00;
    q = (int'($signed(a)) * 16) / int'($signed(b));
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic int predict(input logic [3:0] v, input int last);
    for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Core model: sees start late in the cycle, raises busy next cycle, done after core_lat.
  always begin
    @(negedge clk);
    #3;
    st = bus.o_div_start;
    core_done = 1'b0;
    if (!rst_n) begin
      core_active = 1'b0;
      core_busy   = 1'b0;
    end else begin
      if (core_active) begin
        core_cnt++;
        core_busy = 1'b1;
        if (core_cnt >= core_lat) begin
          core_done   = 1'b1;
          core_busy   = 1'b0;
          core_active = 1'b0;
          core_q      = core_fn(bus.o_div_dividend, bus.o_div_divisor);
          done_cyc    = cyc;
        end
      end
      if (st) begin
        n_starts++;
        start_cyc = cyc;
        if (!core_hang) begin
          core_active = 1'b1;
          core_cnt    = 0;
        end
      end
    end
  end

  task automatic drive_ops();
    for (int k = 0; k < N; k++) begin
      bus.i_req_dividend[k*W +: W] = dvd[k];
      bus.i_req_divisor[k*W +: W]  = dvs[k];
    end
  endtask

  task automatic do_txn(input logic [3:0] vmask, input int busy_n, input int bp_n);
    int g, t_acc, t_rsp, s0, bad;
    logic got;
    logic [3:0] rdy, gmask;
    logic [7:0] qe, a, b;
    g = predict(vmask, model_last);
    gmask = 4'b1 << g;
    got = 1'b0; rdy = '0; t_acc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); #1;
      drive_ops();
      bus.i_req_valid = vmask;
      bus.i_rsp_ready = '0;
      inj_busy = 1'b0;
      #1;
      if (bus.o_req_ready != '0) begin got = 1'b1; rdy = bus.o_req_ready; t_acc = cyc; end
    end
    check("accept_seen", 32'(got), 32'd1);
    if (!got) return;
    check("grant", 32'(rdy), 32'(gmask));
    if (prev_rsp >= 0) check("accept_after_rsp", t_acc, prev_rsp + 1);
    model_last = g; last_g = g;
    a = dvd[g]; b = dvs[g];
    if (b == 8'h00)     qe = a[7] ? 8'h80 : 8'h7F;
    else if (core_hang) qe = 8'h00;
    else                qe = core_fn(a, b);
    s0 = n_starts;
    got = 1'b0; bad = 0; t_rsp = 0;
    for (int k = 1; k < 200 && !got; k++) begin
      @(negedge clk); #1;
      inj_busy = (k <= busy_n);
      bus.i_rsp_ready = ~gmask;
      #1;
      if (bus.o_req_ready != '0) bad++;
      if (bus.o_rsp_valid != '0) begin got = 1'b1; t_rsp = cyc; end
    end
    inj_busy = 1'b0;
    check("rsp_seen", 32'(got), 32'd1);
    check("no_ready_in_flight", bad, 0);
    if (!got) return;
    check("rsp_valid", 32'(bus.o_rsp_valid), 32'(gmask));
    check("rsp_q", 32'(bus.o_rsp_quotient), 32'(qe));
    check("rsp_dbz", 32'(bus.o_rsp_dbz), 32'(b == 8'h00));
    check("rsp_err", 32'(bus.o_rsp_err), 32'((b != 8'h00) && core_hang));
    check("div_operands", 32'({bus.o_div_dividend, bus.o_div_divisor}), 32'({a, b}));
    if (b == 8'h00) begin
      check("dbz_latency", t_rsp, t_acc + 1);
      check("dbz_no_start", n_starts, s0);
    end else begin
      check("start_count", n_starts, s0 + 1);
      check("start_latency", start_cyc, t_acc + 1 + busy_n);
      if (core_hang) check("timeout_latency", t_rsp, start_cyc + TMO + 1);
      else           check("done_latency", t_rsp, done_cyc + 1);
    end
    for (int j = 0; j < bp_n; j++) begin
      @(negedge clk); #1;
      bus.i_rsp_ready = ~gmask;
      #1;
      check("hold_valid", 32'(bus.o_rsp_valid), 32'(gmask));
      check("hold_q", 32'(bus.o_rsp_quotient), 32'(qe));
      check("hold_no_ready", 32'(bus.o_req_ready), 32'd0);
    end
    @(negedge clk); #1;
    bus.i_rsp_ready = 4'hF;
    #1;
    check("final_valid", 32'(bus.o_rsp_valid), 32'(gmask));
    prev_rsp = cyc;
    last_q = qe;
  endtask

  task automatic idle_cycle();
    @(negedge clk); #1;
    bus.i_req_valid = '0;
    bus.i_rsp_ready = '0;
    prev_rsp = -1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
    check({tag, "_q"}, 32'(bus.o_rsp_quotient), 32'd0);
    check({tag, "_dbz_err"}, 32'({bus.o_rsp_dbz, bus.o_rsp_err}), 32'd0);
    check({tag, "_start"}, 32'(bus.o_div_start), 32'd0);
    check({tag, "_operands"}, 32'({bus.o_div_dividend, bus.o_div_divisor}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order [7];
    int exp_rr [7] = '{0, 1, 2, 3, 0, 1, 3};
    int s0;
    bus.i_req_valid = 4'hF;
    bus.i_rsp_ready = '0;
    bus.i_req_dividend = '0;
    bus.i_req_divisor = '0;
    inj_busy = 1'b0; stray_done = 1'b0;
    core_lat = 8; core_hang = 1'b0;
    model_last = N - 1; prev_rsp = -1; last_g = 0; last_q = 8'h00;
    for (int k = 0; k < N; k++) begin dvd[k] = 8'($urandom); dvs[k] = 8'($urandom_range(1, 255)); end
    dvd[0] = 8'h30; dvs[0] = 8'h20;

    @(negedge clk); #2;
    check("reset_req_ready", 32'(bus.o_req_ready), 32'd0);
    check_zero_outputs("reset");
    @(negedge clk); #1;
    bus.i_req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_txn(4'hF, 0, 0);
      order[i] = last_g;
      if (i == 0) check("single_q", 32'(last_q), 32'h18);
    end
    do_txn(4'b1010, 0, 0); order[5] = last_g;
    do_txn(4'b1010, 0, 0); order[6] = last_g;
    for (int i = 0; i < 7; i++) check("rr_order", order[i], exp_rr[i]);

    dvd[0] = 8'h30; dvs[0] = 8'h00;
    do_txn(4'b0001, 0, 0);
    check("dbz_pos", 32'(last_q), 32'h7F);
    dvd[0] = 8'hD0;
    do_txn(4'b0001, 0, 0);
    check("dbz_neg", 32'(last_q), 32'h80);

    dvd[0] = 8'h30; dvs[0] = 8'h20; dvd[2] = 8'hE0; dvs[2] = 8'h18;
    do_txn(4'b0101, 0, 5);
    check("bp_grant", last_g, 2);
    do_txn(4'b0001, 3, 0);
    check("busy_grant", last_g, 0);

    dvd[1] = 8'h50; dvs[1] = 8'h30;
    core_hang = 1'b1;
    do_txn(4'b0010, 0, 0);
    check("timeout_q", 32'(last_q), 32'h00);
    core_hang = 1'b0;
    idle_cycle();
    stray_done = 1'b1;
    @(negedge clk); #1;
    stray_done = 1'b0;
    bus.i_req_valid = '0;
    @(negedge clk); #2;
    check("stray_done_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    prev_rsp = -1;
    do_txn(4'b0010, 0, 0);

    dvd[3] = 8'h90; dvs[3] = 8'h00;
    do_txn(4'b1000, 0, 0);
    for (int k = 0; k < N; k++) begin dvd[k] = 8'h40; dvs[k] = 8'h10; end
    core_lat = 20;
    s0 = n_starts;
    @(negedge clk); #1;
    drive_ops();
    bus.i_req_valid = 4'hF;
    bus.i_rsp_ready = '0;
    for (int k = 0; k < 40 && n_starts == s0; k++) @(negedge clk);
    check("rst_wait_started", n_starts, s0 + 1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_req_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    bus.i_req_valid = '0;
    #1;
    check_zero_outputs("mid_reset");
    model_last = N - 1; prev_rsp = -1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk); #2;
      if (bus.o_rsp_valid != '0) check("no_rsp_after_reset", 32'(bus.o_rsp_valid), 32'd0);
    end
    core_lat = 8;
    do_txn(4'hF, 0, 0);
    check("post_reset_grant", last_g, 0);

    for (int t = 0; t < 40; t++) begin
      logic [3:0] vm;
      vm = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        dvd[k] = 8'($urandom);
        dvs[k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      core_lat  = $urandom_range(1, 12);
      core_hang = ($urandom_range(0, 9) == 0);
      do_txn(vm, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    core_hang = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
